serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial N-bit adder: one full-adder slice plus a carry flip-flop, iterated LSB-first.
//  Accepts two WIDTH-bit operands and a carry-in through a start/ready handshake.
//  Returns Sum/Cout through a valid/ack handshake, WIDTH cycles after the start is accepted.
//  Sits upstream of result consumers; trades area for latency against the ripple adders.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=1)
// PORTS
//  clk        in   1      rising-edge clock (single clock domain)
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request; sampled only when ready=1
//  A          in   WIDTH  operand A, captured on the accepting edge
//  B          in   WIDTH  operand B, captured on the accepting edge
//  Cin        in   1      carry-in, captured on the accepting edge
//  ready      out  1      1 = IDLE, can accept start
//  busy       out  1      1 = SHIFT, addition in progress
//  out_valid  out  1      1 = DONE, Sum/Cout hold the new result
//  out_ack    in   1      consumer acknowledge; sampled only when out_valid=1
//  Sum        out  WIDTH  registered result, (A+B+Cin) mod 2^WIDTH
//  Cout       out  1      registered carry-out, bit WIDTH of A+B+Cin
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ready=1, busy=0, out_valid=0, Sum=0, Cout=0.
//   Internal shift registers, carry FF and bit counter are also cleared; partial work is discarded.
//  FSM states: IDLE, SHIFT, DONE (binary encoded).
//   IDLE: on edge with start=1, load a_sh<=A, b_sh<=B, c<=Cin, cnt<=0; go to SHIFT.
//   SHIFT: each edge computes s=a_sh[0]^b_sh[0]^c and co=maj(a_sh[0],b_sh[0],c).
//    Same edge: c<=co, a_sh/b_sh shift right, s_sh<={s,s_sh[WIDTH-1:1]}, cnt<=cnt+1.
//    On the edge where cnt==WIDTH-1: Sum<={s,s_sh[WIDTH-1:1]}, Cout<=co; go to DONE.
//   DONE: out_valid=1; stay until out_ack=1 is sampled, then go to IDLE.
//  Latency: start accepted at edge t -> out_valid high after edge t+WIDTH (WIDTH SHIFT edges).
//   Throughput: one result per WIDTH+2 cycles minimum (ack in the first DONE cycle).
//  Outputs ready/busy/out_valid decode directly from the state register; they are one-hot.
//  Sum/Cout change only on the SHIFT->DONE edge.
//   They hold their value through DONE, IDLE and the next SHIFT until the next completion.
//  cnt width: $clog2(WIDTH)+1 bits, so WIDTH=1 works (one SHIFT cycle).
//  Boundary rules:
//   start while busy or out_valid: ignored, no effect on the operation in flight.
//   A/B/Cin changes after acceptance: no effect (operands are captured).
//   out_ack while not out_valid: ignored.
//   out_ack and start both high in DONE: go to IDLE only; start is not accepted that cycle.
//   Overflow: A=B=all-ones, Cin=1 -> Sum=all-ones, Cout=1 (no saturation).
//   rst asserted mid-SHIFT: outputs go to reset values immediately; next start begins cleanly.
// TESTING
//  T1 WIDTH=8: A=8'hFF, B=8'h01, Cin=0, start 1 cycle.
//     -> busy 8 cycles, then out_valid=1, Sum=8'h00, Cout=1.
//  T2 A=8'h00, B=8'h00, Cin=1 -> Sum=8'h01, Cout=0.
//     A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Cout=1.
//  T3 start A=8'h3C, B=8'h42, Cin=0, then at SHIFT cycle 3 pulse start with A=8'hFF.
//     -> result still Sum=8'h7E, Cout=0; ready stays 0.
//  T4 hold out_ack=0 for 5 cycles in DONE -> out_valid and Sum stay stable.
//     out_ack+start together -> IDLE, start not taken.
//  T5 assert rst at SHIFT cycle 4 -> async clear: ready=1, Sum=0, Cout=0.
//     A following start of 8'h10+8'h20 -> Sum=8'h30.
//  T6 WIDTH=4 and WIDTH=1: all A,B,Cin combinations back-to-back with ack in the first DONE cycle.
//     -> {Cout,Sum}==A+B+Cin for every case; latency exactly WIDTH.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flip-flop, iterated LSB-first
// over WIDTH cycles, with start/ready on the input side and valid/ack on the output side.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             ready,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] s_sh_reg;
    logic [WIDTH-1:0] s_sh_next;
    logic             c_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             s_bit;
    logic             co_bit;

    // Full-adder slice on the current LSBs and the stored carry.
    always_comb begin
        s_bit  = a_sh_reg[0] ^ b_sh_reg[0] ^ c_reg;
        co_bit = (a_sh_reg[0] & b_sh_reg[0]) | (a_sh_reg[0] & c_reg) | (b_sh_reg[0] & c_reg);
        // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
        s_sh_next = (s_sh_reg >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            s_sh_reg  <= '0;
            c_reg     <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg  <= A;
                        b_sh_reg  <= B;
                        c_reg     <= Cin;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    c_reg    <= co_bit;
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    s_sh_reg <= s_sh_next;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        sum_reg   <= s_sh_next;
                        cout_reg  <= co_bit;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // A start coinciding with the ack is dropped; the next one is taken from IDLE.
                    if (out_ack) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready     = (state_reg == IDLE);
    assign busy      = (state_reg == SHIFT);
    assign out_valid = (state_reg == DONE);
    assign Sum       = sum_reg;
    assign Cout      = cout_reg;

endmodule
